// File: rtl/cache_arbiter.sv
// Two-client arbiter between the split L1 I/D caches and one physical-memory port.
// Round-robin grants, with a lock that keeps a D-cache writeback and its refill back to back.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                wb_lock_q, wb_lock_d;
  logic                pmem_read_q, pmem_read_d;
  logic                pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0]   pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0]   pmem_wdata_q, pmem_wdata_d;

  logic                i_req_s;
  logic                d_req_s;
  logic                grant_valid_s;
  logic                grant_id_s;

  assign i_req_s = i_pmem_read;
  assign d_req_s = d_pmem_read | d_pmem_write;

  // Arbitration on the requests sampled while idle
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = GRANT_I;
    if (wb_lock_q && d_req_s) begin
      // A locked D refill (or any D request) goes ahead of a waiting I request
      grant_valid_s = 1'b1;
      grant_id_s    = GRANT_D;
    end else if (i_req_s && d_req_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = GRANT_D;
    end else if (i_req_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = GRANT_I;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = GRANT_I;
    end
  end

  // Next-state, latched transaction and memory-strobe logic
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    wb_lock_d      = wb_lock_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;

    case (state_q)
      IDLE: begin
        if (!d_pmem_read) begin
          wb_lock_d = 1'b0;
        end else begin
          wb_lock_d = wb_lock_q;
        end
        if (grant_valid_s && (grant_id_s == GRANT_D)) begin
          state_d        = SERVE_D;
          last_grant_d   = GRANT_D;
          wb_lock_d      = 1'b0;
          pmem_address_d = d_pmem_address;
          pmem_wdata_d   = d_pmem_wdata;
          // Both strobes high is illegal; the writeback wins
          pmem_write_d   = d_pmem_write;
          pmem_read_d    = ~d_pmem_write;
        end else if (grant_valid_s) begin
          state_d        = SERVE_I;
          last_grant_d   = GRANT_I;
          pmem_address_d = i_pmem_address;
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          if ((state_q == SERVE_D) && pmem_write_q) begin
            wb_lock_d = 1'b1;
          end else begin
            wb_lock_d = wb_lock_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d      = IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  // State and transaction registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_I;
      wb_lock_q      <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= {ADDR_W{1'b0}};
      pmem_wdata_q   <= {LINE_W{1'b0}};
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      wb_lock_q      <= wb_lock_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  // Responses go only to the owner of the transaction, and only if it is still asking
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = pmem_resp & (state_q == SERVE_I) & i_req_s;
  assign d_pmem_resp  = pmem_resp & (state_q == SERVE_D) & d_req_s;

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Sits directly downstream of the split L1 caches (I-cache and D-cache controllers) and in front of the single physical-memory port.
- Multiplexes the two caches' 256-bit line read/write requests onto one pmem interface, one transaction at a time.
- Arbitration is round-robin, plus a writeback-fill lock so a D-cache eviction and its refill run back to back.
- Each cache sees a private pmem interface with a per-client response strobe.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_pmem_read  in  1  I-cache line read request
- i_pmem_address  in  ADDR_W  I-cache line address
- i_pmem_rdata  out  LINE_W  line data to I-cache
- i_pmem_resp  out  1  I-cache transaction complete
- d_pmem_read  in  1  D-cache line read request
- d_pmem_write  in  1  D-cache line writeback request
- d_pmem_address  in  ADDR_W  D-cache line address
- d_pmem_wdata  in  LINE_W  D-cache writeback data
- d_pmem_rdata  out  LINE_W  line data to D-cache
- d_pmem_resp  out  1  D-cache transaction complete
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory transaction complete, one-cycle pulse

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=I, wb_lock=0.
  - pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0.
  - i_pmem_resp=d_pmem_resp=0.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE, arbitration on sampled requests:
  - wb_lock=1 and d_pmem_read: grant D.
  - Only one client requesting: grant that client.
  - Both requesting: grant the client not equal to last_grant.
  - Neither requesting: stay in IDLE.
- On grant, latch the following into internal registers on that edge and move to SERVE_x:
  - address
  - direction: I is always a read; D is a write if d_pmem_write, else a read
  - wdata
  - granted id into last_grant
- d_pmem_read and d_pmem_write both high is illegal; write takes precedence.
- SERVE_x memory-side drive:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are driven from the latched registers only; live client inputs are ignored.
  - These outputs are registered and asserted from the first SERVE cycle until the pmem_resp cycle inclusive.
- Response path:
  - pmem_rdata is passed through combinationally to both i_pmem_rdata and d_pmem_rdata.
  - x_pmem_resp = pmem_resp AND state==SERVE_x AND client x still requesting. Combinational, same cycle as pmem_resp.
  - On pmem_resp, go to IDLE next cycle.
  - Memory strobes deassert the cycle after pmem_resp.
- wb_lock:
  - Set when a D write completes.
  - Cleared when the next D grant occurs, or when IDLE sees no d_pmem_read.
  - While wb_lock=1, a waiting I request is not granted unless D is idle.
- Latency:
  - Request first high in cycle N (arbiter in IDLE): pmem strobe in cycle N+1.
  - pmem_resp at cycle M: client resp at M, IDLE at M+1, next grant's strobe no earlier than M+2.
- Request dropped mid-transfer (client deasserts before pmem_resp):
  - Arbiter keeps driving the latched transaction to completion.
  - Response is discarded; no client resp pulse.
  - Returns to IDLE.
- pmem_resp in IDLE: ignored; no client resp.
- Reset mid-transaction:
  - Next cycle state=IDLE and all strobes=0; the in-flight memory transaction is abandoned.
  - No resp pulse is delivered to either client.
- A client never receives a resp for the other client's transaction.

Test Plan:
- I read alone, addr 0x0000_1000, memory returns resp 3 cycles after strobe with rdata=0xA5..A5 → pmem_read high from cycle N+1; i_pmem_resp high one cycle with i_pmem_rdata=0xA5..A5; d_pmem_resp stays 0.
- Both read in the same cycle after reset → D served first (last_grant=I), then I. pmem_address sequence is D addr then I addr; each client gets exactly one resp.
- D write 0x0000_2000 (wdata=0xDEAD..BEEF), then D read 0x0000_3000 the cycle after resp, with I reading throughout → write, then D read granted (wb_lock), then I. pmem_wdata matches on the write.
- D changes d_pmem_address to 0x0000_4000 mid-transfer → pmem_address stays at the latched 0x0000_3000 until pmem_resp.
- I drops its request mid-transfer → pmem_read held until pmem_resp; i_pmem_resp stays 0; arbiter back in IDLE.
- rst asserted during SERVE_D → next cycle pmem_read=pmem_write=0 and state IDLE. A pmem_resp in that cycle produces no client resp.
